// File: rtl/pwm_decoder_pkg.sv
// pwm_pkg: shared PWM resolution, counter width derivation and decoder FSM encoding.
package pwm_pkg;
  localparam int PWM_RESOLUTION = 8;
  function automatic int cnt_w(input int res);
    return res + 2;
  endfunction
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_e;
endpackage

// File: rtl/pwm_decoder_if.sv
// pwm_decoder_if: result bundle published by the PWM decoder.
interface pwm_decoder_if import pwm_pkg::*; #(
  parameter int RESOLUTION = PWM_RESOLUTION,
  parameter int CNT_W = cnt_w(RESOLUTION)
);
  logic [RESOLUTION-1:0] o_duty;
  logic [CNT_W-1:0] o_high_cnt;
  logic [CNT_W-1:0] o_period_cnt;
  logic o_valid;
  logic o_period_err;
  logic o_static;
  modport master(output o_duty, o_high_cnt, o_period_cnt, o_valid, o_period_err, o_static);
  modport slave(input o_duty, o_high_cnt, o_period_cnt, o_valid, o_period_err, o_static);
endinterface

// File: rtl/pwm_decoder_sync_edge.sv
// sync_edge: multi-stage synchronizer followed by a registered rise/fall detector.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic s,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync_q, sync_d;
  logic s_d_q, s_d_d;
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    s_d_d = sync_q[STAGES-1];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      s_d_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      s_d_q <= s_d_d;
    end
  end
  assign s = sync_q[STAGES-1];
  assign rise = s & ~s_d_q;
  assign fall = ~s & s_d_q;
endmodule

// File: rtl/pwm_decoder.sv
// pwm_decoder: measures high time and period of a PWM input and recovers its duty word.
module pwm_decoder import pwm_pkg::*; #(
  parameter int RESOLUTION = PWM_RESOLUTION,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT = 2 ** (RESOLUTION + 1)
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pwm,
  pwm_decoder_if.master res
);
  localparam int CNT_W = cnt_w(RESOLUTION);
  localparam int IDLE_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] NOM_PER = CNT_W'(2 ** RESOLUTION);
  localparam logic [CNT_W-1:0] DUTY_LIM = CNT_W'(2 ** RESOLUTION - 1);
  localparam logic [RESOLUTION-1:0] DUTY_MAX = '1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
  logic s, rise, fall, any_edge, timeout;
  state_e state_q, state_d;
  logic [CNT_W-1:0] high_q, high_d, per_q, per_d, high_inc, per_inc;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [RESOLUTION-1:0] duty_q, duty_d;
  logic [CNT_W-1:0] hc_q, hc_d, pc_q, pc_d;
  logic valid_q, valid_d, err_q, err_d, static_q, static_d;
  sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (i_clk),
    .rst (i_rst),
    .d   (i_pwm),
    .s   (s),
    .rise(rise),
    .fall(fall)
  );
  assign any_edge = rise | fall;
  assign timeout = !any_edge && idle_q == IDLE_LAST;
  assign high_inc = (high_q == CNT_MAX) ? high_q : high_q + 1'b1;
  assign per_inc = (per_q == CNT_MAX) ? per_q : per_q + 1'b1;
  always_comb begin
    state_d = state_q;
    high_d = high_q;
    per_d = per_q;
    idle_d = any_edge ? '0 : idle_q + 1'b1;
    duty_d = duty_q;
    hc_d = hc_q;
    pc_d = pc_q;
    valid_d = 1'b0;
    err_d = err_q;
    static_d = static_q;
    unique case (state_q)
      IDLE: if (rise) begin
        state_d = HIGH;
        high_d = CNT_W'(1);
        per_d = CNT_W'(1);
      end
      HIGH: begin
        state_d = fall ? LOW : HIGH;
        high_d = fall ? high_q : high_inc;
        per_d = per_inc;
      end
      LOW: if (rise) begin
        state_d = HIGH;
        high_d = CNT_W'(1);
        per_d = CNT_W'(1);
        valid_d = 1'b1;
        hc_d = high_q;
        pc_d = per_q;
        err_d = per_q != NOM_PER || high_q == CNT_MAX;
        duty_d = (high_q > DUTY_LIM) ? DUTY_MAX : high_q[RESOLUTION-1:0];
        static_d = 1'b0;
      end else begin
        per_d = per_inc;
      end
      default: state_d = IDLE;
    endcase
    // A static level abandons any partial measurement and re-arms from IDLE.
    if (timeout) begin
      state_d = IDLE;
      high_d = '0;
      per_d = '0;
      idle_d = '0;
      valid_d = 1'b1;
      hc_d = '0;
      pc_d = '0;
      err_d = 1'b0;
      static_d = 1'b1;
      duty_d = s ? DUTY_MAX : '0;
    end
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      high_q <= '0;
      per_q <= '0;
      idle_q <= '0;
      duty_q <= '0;
      hc_q <= '0;
      pc_q <= '0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
      static_q <= 1'b0;
    end else begin
      state_q <= state_d;
      high_q <= high_d;
      per_q <= per_d;
      idle_q <= idle_d;
      duty_q <= duty_d;
      hc_q <= hc_d;
      pc_q <= pc_d;
      valid_q <= valid_d;
      err_q <= err_d;
      static_q <= static_d;
    end
  end
  assign res.o_duty = duty_q;
  assign res.o_high_cnt = hc_q;
  assign res.o_period_cnt = pc_q;
  assign res.o_valid = valid_q;
  assign res.o_period_err = err_q;
  assign res.o_static = static_q;
endmodule

// File: tb/tb_pwm_decoder.sv
// tb_pwm_decoder: directed PWM waveforms with a queued scoreboard checked on every o_valid.
module tb_pwm_decoder;
  typedef struct {
    logic [7:0] duty;
    logic [9:0] hc;
    logic [9:0] pc;
    logic err;
    logic st;
    int gap;
  } exp_t;
  logic clk, rst, pwm;
  int checks = 0, failures = 0, cyc = 0, last_v = 0;
  int pend_h, pend_p;
  bit pend, chained;
  exp_t q[$];
  exp_t mon_e;
  pwm_decoder_if #(.RESOLUTION(8)) bus ();
  pwm_decoder dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_pwm(pwm),
    .res  (bus.master)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (!rst && bus.o_valid) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_valid at cyc %0d duty=%0d hc=%0d pc=%0d st=%0d", cyc, bus.o_duty,
                 bus.o_high_cnt, bus.o_period_cnt, bus.o_static);
      end else begin
        mon_e = q.pop_front();
        if ({bus.o_duty, bus.o_high_cnt, bus.o_period_cnt, bus.o_period_err, bus.o_static} !==
            {mon_e.duty, mon_e.hc, mon_e.pc, mon_e.err, mon_e.st}) begin
          failures++;
          $display("FAIL result at cyc %0d got duty=%0d hc=%0d pc=%0d err=%0d st=%0d expected duty=%0d hc=%0d pc=%0d err=%0d st=%0d",
                   cyc, bus.o_duty, bus.o_high_cnt, bus.o_period_cnt, bus.o_period_err, bus.o_static,
                   mon_e.duty, mon_e.hc, mon_e.pc, mon_e.err, mon_e.st);
        end
        if (mon_e.gap != 0) begin
          checks++;
          if (cyc - last_v != mon_e.gap) begin
            failures++;
            $display("FAIL valid_gap at cyc %0d got %0d expected %0d", cyc, cyc - last_v, mon_e.gap);
          end
        end
      end
      last_v = cyc;
    end
  end
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic check_zero(input string name);
    checks++;
    if ({bus.o_duty, bus.o_high_cnt, bus.o_period_cnt, bus.o_valid, bus.o_period_err, bus.o_static} !== '0) begin
      failures++;
      $display("FAIL %s got duty=%0d hc=%0d pc=%0d v=%0d err=%0d st=%0d expected all 0", name, bus.o_duty,
               bus.o_high_cnt, bus.o_period_cnt, bus.o_valid, bus.o_period_err, bus.o_static);
    end
  endtask
  task automatic push_pend();
    exp_t e;
    if (pend) begin
      e.hc = 10'(pend_h);
      e.pc = 10'(pend_p);
      e.duty = (pend_h > 255) ? 8'd255 : 8'(pend_h);
      e.err = pend_p != 256;
      e.st = 1'b0;
      e.gap = chained ? pend_p : 0;
      q.push_back(e);
      chained = 1;
    end
    pend = 0;
  endtask
  task automatic run_period(input int h, input int p);
    push_pend();
    pwm = 1;
    wait_clk(h);
    pwm = 0;
    wait_clk(p - h);
    pend = 1;
    pend_h = h;
    pend_p = p;
  endtask
  task automatic go_static(input bit lvl, input int n);
    exp_t e;
    if (lvl) push_pend();
    pend = 0;
    chained = 0;
    for (int i = 0; i < n; i++) begin
      e.duty = lvl ? 8'd255 : 8'd0;
      e.hc = '0;
      e.pc = '0;
      e.err = 1'b0;
      e.st = 1'b1;
      e.gap = (i == 0) ? 0 : 512;
      q.push_back(e);
    end
    pwm = lvl;
    wait_clk(n * 512 + 100);
  endtask
  initial begin
    int duties[3] = '{1, 128, 255};
    rst = 1;
    pwm = 0;
    pend = 0;
    chained = 0;
    wait_clk(3);
    check_zero("reset_state");
    rst = 0;
    go_static(0, 2);
    repeat (5) run_period(64, 256);
    foreach (duties[k]) repeat (3) run_period(duties[k], 256);
    go_static(0, 2);
    go_static(1, 2);
    pwm = 0;
    wait_clk(50);
    repeat (4) run_period(32, 256);
    repeat (3) run_period(100, 300);
    repeat (3) run_period(300, 400);
    push_pend();
    pwm = 1;
    wait_clk(30);
    #3 rst = 1;
    #1 check_zero("reset_mid_high");
    pend = 0;
    chained = 0;
    wait_clk(34);
    pwm = 0;
    wait_clk(50);
    rst = 0;
    wait_clk(50);
    repeat (3) run_period(64, 256);
    push_pend();
    pwm = 1;
    wait_clk(20);
    pwm = 0;
    for (int i = 0; i < 50 && q.size() != 0; i++) wait_clk(1);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d pending results expected 0", q.size());
    end
    wait_clk(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
